trig_acquire: RTL

Triggered burst acquisition: the consumer of the delayed trigger/valid pair produced by the trigger-alignment logic. On a trigger pulse it latches the requested frame length and writes that many valid samples into a dual-port BRAM write port. When the frame is complete it returns `ready` high so the upstream trigger stage can re-arm. It sits between the ADC/DSP sample stream and the BRAM read back over AXI by the software driver.

---
 rtl/trig_acquire_pkg.sv | 11 +
 rtl/sat_counter.sv | 21 ++
 rtl/trig_acquire.sv | 98 +++++++++
 3 files changed

// File: rtl/trig_acquire_pkg.sv
// Shared types and constants for the triggered burst acquisition block.
package trig_acquire_pkg;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    CAPTURE = 1'b1
  } state_t;

  localparam logic [15:0] MISSED_MAX = 16'hFFFF;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at MAX instead of wrapping; synchronous active-high reset.
module sat_counter #(
  parameter int               WIDTH = 16,
  parameter logic [WIDTH-1:0] MAX   = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != MAX)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/trig_acquire.sv
// Triggered burst acquisition: on trig, writes the next nsamples valid samples
// into a BRAM write port, then returns ready so the trigger stage can re-arm.
module trig_acquire
  import trig_acquire_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  trig,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  valid_in,
  input  logic [ADDR_WIDTH:0]   nsamples,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  output logic [DATA_WIDTH-1:0] bram_din,
  output logic                  bram_we,
  output logic                  ready,
  output logic                  done,
  output logic [31:0]           frame_count,
  output logic [15:0]           missed_count
);

  localparam logic [ADDR_WIDTH:0] MAX_LEN = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] ONE     = {{ADDR_WIDTH{1'b0}}, 1'b1};

  state_t                state;
  logic [ADDR_WIDTH:0]   len;
  logic [ADDR_WIDTH:0]   wr_cnt;

  logic [ADDR_WIDTH:0]   len_req;
  logic [ADDR_WIDTH:0]   cur_len;
  logic [ADDR_WIDTH:0]   cur_cnt;
  logic                  idle_trig;
  logic                  accept;
  logic                  last;
  logic                  empty_frame;
  logic                  missed;

  // The trigger cycle itself may carry sample 0, so the length/count used this
  // cycle come straight from the request rather than the (not yet loaded) registers.
  // NOTE: every always_comb output gets a value on every path, so no latches are inferred.
  always_comb begin
    len_req     = (nsamples > MAX_LEN) ? MAX_LEN : nsamples;
    idle_trig   = (state == IDLE) && trig;
    cur_len     = idle_trig ? len_req : len;
    cur_cnt     = idle_trig ? '0 : wr_cnt;
    accept      = valid_in && ((state == CAPTURE) || (idle_trig && (len_req != '0)));
    last        = accept && (cur_cnt == cur_len - ONE);
    empty_frame = idle_trig && (len_req == '0);
    missed      = trig && (state == CAPTURE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      len         <= '0;
      wr_cnt      <= '0;
      bram_we     <= 1'b0;
      bram_addr   <= '0;
      bram_din    <= '0;
      done        <= 1'b0;
      frame_count <= '0;
    end else begin
      bram_we <= accept;
      done    <= last || empty_frame;
      if (accept) begin
        bram_addr <= cur_cnt[ADDR_WIDTH-1:0];
        bram_din  <= data_in;
        wr_cnt    <= cur_cnt + ONE;
      end else if (idle_trig) begin
        wr_cnt <= '0;
      end
      if (idle_trig) len <= len_req;
      if (last || empty_frame) frame_count <= frame_count + 1'b1;

      // A one-sample frame completes on its trigger cycle and never leaves IDLE.
      if (idle_trig && (len_req != '0) && !last) begin
        state <= CAPTURE;
      end else if ((state == CAPTURE) && last) begin
        state <= IDLE;
      end
    end
  end

  assign ready = (state == IDLE);

  sat_counter #(
    .WIDTH (16),
    .MAX   (MISSED_MAX)
  ) u_missed_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (missed),
    .count (missed_count)
  );

endmodule
